// File: rtl/instruction_dispatch_controller.sv
// instruction_dispatch_controller
//
// Sequencer between the instruction FIFO and the TPU core. Pops the FIFO head
// when the core can accept work and issues it as a one-cycle strobe. NOP and
// SYNC opcodes are consumed here; a SYNC drains the core and then pulses
// `synchronize` to the host. Issue and stall counters support profiling.
//
// Ports:
//   clk                     single clock
//   rst                     synchronous active-high reset
//   enable                  dispatch enable; low blocks new pops only
//   fifo_instruction        FIFO head (first-word-fall-through)
//   fifo_empty              FIFO empty flag
//   fifo_next_en            combinational pop, head consumed at this edge
//   core_instruction        registered instruction to the core
//   core_instruction_enable one-cycle issue strobe
//   core_busy               core busy, asserts <= 1 cycle after the strobe
//   synchronize             one-cycle pulse on SYNC completion
//   sync_error              sticky, set when a SYNC drain times out
//   issue_count             instructions issued, wraps
//   stall_count             cycles the head was blocked by core_busy, saturates
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | decide on the FIFO head: pop NOP/SYNC, issue, or stall
// HOLD       | strobe cycle; covers the core's busy-assertion latency
// DRAIN      | SYNC in progress, waiting for DRAIN_CYCLES idle core cycles
// SYNC_PULSE | synchronize asserted for one cycle

module instruction_dispatch_controller #(
  parameter int INSTRUCTION_WIDTH = 80,
  parameter int DRAIN_CYCLES      = 3,
  parameter int SYNC_TIMEOUT      = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [INSTRUCTION_WIDTH-1:0] fifo_instruction,
  input  logic                         fifo_empty,
  output logic                         fifo_next_en,
  output logic [INSTRUCTION_WIDTH-1:0] core_instruction,
  output logic                         core_instruction_enable,
  input  logic                         core_busy,
  output logic                         synchronize,
  output logic                         sync_error,
  output logic [31:0]                  issue_count,
  output logic [31:0]                  stall_count
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_SYNC = 8'hFF;

  // Counters run 0..N-1; the drain completes on the cycle the counter would
  // reach N, so the exit decision is made on the last counted cycle.
  localparam int IDLE_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int TO_W   = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SYNC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOLD       = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_SYNC_PULSE = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic [7:0] opcode;
  logic       is_nop;
  logic       is_sync;
  logic       pop;
  logic       pop_core;
  logic       pop_sync;
  logic       stall_inc;
  logic       drain_timeout;

  assign opcode  = fifo_instruction[INSTRUCTION_WIDTH-1 -: 8];
  assign is_nop  = (opcode == OP_NOP);
  assign is_sync = (opcode == OP_SYNC);

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    pop_core      = 1'b0;
    pop_sync      = 1'b0;
    stall_inc     = 1'b0;
    drain_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          if (is_nop) begin
            pop = 1'b1;
          end else if (is_sync) begin
            pop      = 1'b1;
            pop_sync = 1'b1;
            state_d  = ST_DRAIN;
          end else if (!core_busy) begin
            pop      = 1'b1;
            pop_core = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            stall_inc = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // A drain that completes on the timeout cycle still counts as clean.
        if (!core_busy && (idle_cnt_q == IDLE_LAST)) begin
          state_d = ST_SYNC_PULSE;
        end else if (to_cnt_q == TO_LAST) begin
          drain_timeout = 1'b1;
          state_d       = ST_SYNC_PULSE;
        end
      end
      ST_SYNC_PULSE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // No pop may escape while reset is held; the FIFO would lose a word.
  assign fifo_next_en            = pop & ~rst;
  assign core_instruction_enable = (state_q == ST_HOLD);
  assign synchronize             = (state_q == ST_SYNC_PULSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      idle_cnt_q       <= '0;
      to_cnt_q         <= '0;
      core_instruction <= '0;
      sync_error       <= 1'b0;
      issue_count      <= '0;
      stall_count      <= '0;
    end else begin
      state_q <= state_d;

      if (pop_core) begin
        core_instruction <= fifo_instruction;
        issue_count      <= issue_count + 32'd1;
      end

      if (stall_inc && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end

      if (pop_sync) begin
        idle_cnt_q <= '0;
        to_cnt_q   <= '0;
      end else if (state_q == ST_DRAIN) begin
        idle_cnt_q <= core_busy ? '0 : idle_cnt_q + IDLE_W'(1);
        to_cnt_q   <= to_cnt_q + TO_W'(1);
      end

      if (drain_timeout) begin
        sync_error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/instruction_dispatch_controller.md
# instruction_dispatch_controller

Sequencer between the instruction FIFO and the TPU core. Pops the FIFO head when the core can accept work and issues it as a one-cycle `instruction_enable` pulse. Consumes NOP and SYNC opcodes locally; a SYNC drains the core and then pulses `synchronize` to the host. Keeps issue and stall counters for host-side profiling.

## Interface
Parameters:
- `INSTRUCTION_WIDTH`, 80, instruction word width (lower 32 + middle 32 + upper 16).
- `DRAIN_CYCLES`, 3, consecutive idle cycles of `core_busy` required before a SYNC completes.
- `SYNC_TIMEOUT`, 4096, maximum drain cycles before `sync_error` is raised.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1. Reset is synchronous and active-high.
- `enable`, in, 1, dispatch enable; when low, no new FIFO pops.
- `fifo_instruction`, in, INSTRUCTION_WIDTH, FIFO head, first-word-fall-through; valid when `fifo_empty`=0.
- `fifo_empty`, in, 1, FIFO empty flag.
- `fifo_next_en`, out, 1, combinational pop; the head is consumed at this clock edge.
- `core_instruction`, out, INSTRUCTION_WIDTH, registered instruction to the core.
- `core_instruction_enable`, out, 1, one-cycle issue strobe.
- `core_busy`, in, 1, core busy; asserts no later than 1 cycle after the strobe.
- `synchronize`, out, 1, one-cycle pulse on SYNC completion.
- `sync_error`, out, 1, sticky; set on SYNC timeout.
- `issue_count`, out, 32, instructions issued to the core; wraps.
- `stall_count`, out, 32, cycles the head was blocked by `core_busy`; saturates at 0xFFFF_FFFF.

## Operation
- Opcode is `fifo_instruction[INSTRUCTION_WIDTH-1 -: 8]`.
  - 0x00: NOP.
  - 0xFF: SYNC.
  - All other values: core instruction.
- States:
  - IDLE
  - HOLD
  - DRAIN
  - SYNC_PULSE
- IDLE, when `enable`=1 and `fifo_empty`=0:
  - NOP: pop; stay IDLE; nothing issued.
  - SYNC: pop; go to DRAIN; clear the drain-idle and timeout counters.
  - Core opcode with `core_busy`=0: pop; capture head into `core_instruction`; go to HOLD.
  - Core opcode with `core_busy`=1: no pop; `stall_count`+1.
- IDLE with `enable`=0 or FIFO empty: no pop; counters hold.
- HOLD: lasts exactly 1 cycle. It covers the core's busy-assertion latency. No pop. Returns to IDLE.
- DRAIN:
  - Idle counter increments while `core_busy`=0 and resets to 0 when `core_busy`=1.
  - When the idle counter reaches DRAIN_CYCLES, go to SYNC_PULSE.
  - The timeout counter increments every DRAIN cycle. When it reaches SYNC_TIMEOUT, set `sync_error` and go to SYNC_PULSE anyway.
- SYNC_PULSE: assert `synchronize` for 1 cycle; return to IDLE.
- `enable` deassertion only blocks pops in IDLE. HOLD, DRAIN and SYNC_PULSE always complete.
- `issue_count` increments by 1 per `core_instruction_enable` pulse, modulo 2^32.

## Timing
- Issue path:
  - Pop decision at cycle T (`fifo_next_en`=1 at T).
  - At T+1: `core_instruction_enable`=1, `core_instruction` holds the popped word, state is HOLD.
  - At T+2: IDLE, and a new decision may be made.
  - Peak issue rate is 1 instruction per 2 cycles.
- NOP throughput is 1 per cycle.
- SYNC with the core already idle: pop at T, DRAIN from T+1; `synchronize`=1 at T+1+DRAIN_CYCLES.
- `core_instruction` holds its last value between issues.
- `fifo_next_en` is never asserted while `fifo_empty`=1 or outside IDLE.
- Reset values:
  - state IDLE
  - `fifo_next_en`=0, `core_instruction_enable`=0
  - `core_instruction`=0
  - `synchronize`=0, `sync_error`=0
  - `issue_count`=0, `stall_count`=0
- Reset mid-DRAIN or mid-HOLD: state is discarded. No `synchronize` pulse follows, and no instruction is re-issued.
- `sync_error` clears only on `rst`.

## Test plan
- Reset, then 3 core opcodes (0x10, 0x20, 0x30) with `core_busy`=0 → strobes at cycles 1, 3, 5 after the first decision, carrying those words in order; `issue_count`=3.
- Head 0x10 with `core_busy` held high for 5 cycles → no pop for 5 cycles; `stall_count`=5; issue occurs the cycle after `core_busy` falls.
- NOP, NOP, core opcode → 2 pops with no strobes, then 1 strobe; `issue_count`=1.
- SYNC while `core_busy` is high for 4 more cycles and then drops → `synchronize` pulses exactly DRAIN_CYCLES=3 cycles after `core_busy` falls; one pulse only.
- SYNC with `core_busy` stuck high and SYNC_TIMEOUT=16 → `sync_error`=1 and `synchronize` pulses after 16 drain cycles; `sync_error` stays set until `rst`.
- `rst` asserted during DRAIN, and separately `enable`=0 with a non-empty FIFO → all outputs at reset values and no pops; in the second case dispatch resumes one cycle after `enable` rises.
